// File: rtl/led_scan_pkg.sv
// Shared types and sizing helpers for the LED result scanner.
package led_scan_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SHOW = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   // Number of LED_W-wide slices needed to cover the whole result word.
   function automatic int calc_nslice(input int data_w, input int led_w);
      return (data_w + led_w - 1) / led_w;
   endfunction

   // Slice index width; a single-slice build still gets a 1-bit index.
   function automatic int calc_idx_w(input int nslice);
      return (nslice <= 2) ? 1 : $clog2(nslice);
   endfunction

   // Dwell/gap counter width, sized for the larger of the two limits.
   function automatic int calc_cnt_w(input int dwell, input int gap);
      int m;
      m = dwell;
      if (gap > m) m = gap;
      if (m < 2) m = 2;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/led_slice_mux.sv
// Picks one LED_W slice out of the captured word. The top slice is
// zero-padded past DATA_W; an index beyond the last slice yields zero.
module led_slice_mux #(
   parameter int DATA_W = 10,
   parameter int LED_W  = 4,
   parameter int NSLICE = 3,
   parameter int IDX_W  = 2
) (
   input  logic [DATA_W-1:0] shadow,
   input  logic [IDX_W-1:0]  idx,
   output logic [LED_W-1:0]  slice
);

   localparam int PAD_W = NSLICE * LED_W;

   logic [PAD_W-1:0] padded;

   assign padded = PAD_W'(shadow);

   // Decode the index against every legal slice; no match leaves zero.
   always_comb begin
      slice = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (idx == IDX_W'(k)) slice = padded[k*LED_W +: LED_W];
      end
   end

endmodule

// File: rtl/led_result_scanner.sv
// Board LED result display: captures a wide result word and shows it one
// LED_W slice at a time, either auto-scanning with blank gaps or showing a
// selected slice statically.
// Optional build macro LED_PWM_EN adds PWM_DUTY dimming of the LED bank.
//
//   state  | meaning
//   S_IDLE | nothing captured yet, LEDs dark
//   S_SHOW | presenting a slice (scan: dwell timing, static: slice[sel])
//   S_GAP  | blank interval between scanned slices
module led_result_scanner
   import led_scan_pkg::*;
#(
   parameter int DATA_W       = 10,
   parameter int LED_W        = 4,
   parameter int DWELL_CYCLES = 50000000,
   parameter int GAP_CYCLES   = 12500000,
`ifdef LED_PWM_EN
   parameter int PWM_DUTY     = 2,
`endif
   localparam int NSLICE      = calc_nslice(DATA_W, LED_W),
   localparam int IDX_W       = calc_idx_w(NSLICE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   input  logic              scan_en,
   input  logic [IDX_W-1:0]  sel,
   output logic [LED_W-1:0]  led,
   output logic [IDX_W-1:0]  slice_idx,
   output logic              has_data
);

   localparam int CNT_W  = calc_cnt_w(DWELL_CYCLES, GAP_CYCLES);
   localparam int GAP_M1 = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_M1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NSLICE - 1);

   state_t              state;
   logic [DATA_W-1:0]   shadow;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic                scan_q;
   logic [IDX_W-1:0]    mux_idx;
   logic [IDX_W-1:0]    idx_next;
   logic [LED_W-1:0]    slice;
   logic [LED_W-1:0]    led_next;

   assign mux_idx   = scan_en ? idx : sel;
   assign idx_next  = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
   assign slice_idx = idx;

   led_slice_mux #(
      .DATA_W (DATA_W),
      .LED_W  (LED_W),
      .NSLICE (NSLICE),
      .IDX_W  (IDX_W)
   ) u_mux (
      .shadow (shadow),
      .idx    (mux_idx),
      .slice  (slice)
   );

`ifdef LED_PWM_EN
   logic [2:0] pwm_cnt;
   logic       pwm_on;

   assign pwm_on = (int'(pwm_cnt) < PWM_DUTY);

   // Free-running dimming phase counter.
   always_ff @(posedge clk) begin
      if (!rst_n) pwm_cnt <= '0;
      else        pwm_cnt <= pwm_cnt + 3'd1;
   end
`endif

   // Next LED value: the selected slice only while showing, optionally dimmed.
   always_comb begin
      led_next = (state == S_SHOW) ? slice : '0;
`ifdef LED_PWM_EN
      if (!pwm_on) led_next = '0;
`endif
   end

   // Capture, mode handling and dwell/gap sequencing; LEDs lag state by one edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         shadow   <= '0;
         has_data <= 1'b0;
         idx      <= '0;
         cnt      <= '0;
         scan_q   <= 1'b0;
         led      <= '0;
      end else begin
         scan_q <= scan_en;
         led    <= led_next;
         if (data_valid) begin
            shadow   <= data_in;
            has_data <= 1'b1;
            idx      <= '0;
            cnt      <= '0;
            state    <= S_SHOW;
         end else begin
            case (state)
               S_SHOW: begin
                  if (!scan_en) begin
                     idx <= sel;
                     cnt <= '0;
                  end else if (!scan_q) begin
                     idx <= '0;
                     cnt <= '0;
                  end else if (cnt == DWELL_LAST) begin
                     cnt <= '0;
                     if (GAP_CYCLES == 0) idx <= idx_next;
                     else                 state <= S_GAP;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               S_GAP: begin
                  if (!scan_en) begin
                     idx   <= sel;
                     cnt   <= '0;
                     state <= S_SHOW;
                  end else if (!scan_q) begin
                     idx   <= '0;
                     cnt   <= '0;
                     state <= S_SHOW;
                  end else if (cnt == GAP_LAST) begin
                     cnt   <= '0;
                     idx   <= idx_next;
                     state <= S_SHOW;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_result_scanner.sv
// Self-checking bench for led_result_scanner (DATA_W=10, LED_W=4,
// DWELL_CYCLES=4, GAP_CYCLES=2). Honours LED_PWM_EN when defined.
module tb_led_result_scanner;

   localparam int DW     = 10;
   localparam int LW     = 4;
   localparam int DWELL  = 4;
   localparam int GAP    = 2;
   localparam int NS     = 3;
   localparam int PER    = DWELL + GAP;
   localparam int DUTY   = 2;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] data_in;
   logic          data_valid;
   logic          scan_en;
   logic [1:0]    sel;
   logic [LW-1:0] led;
   logic [1:0]    slice_idx;
   logic          has_data;

   int tests_run = 0;
   int tests_failed = 0;
   int pwm_now = 0;
   int pwm_used = 0;

   led_result_scanner #(
      .DATA_W       (DW),
      .LED_W        (LW),
      .DWELL_CYCLES (DWELL),
`ifdef LED_PWM_EN
      .PWM_DUTY     (DUTY),
`endif
      .GAP_CYCLES   (GAP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .scan_en    (scan_en),
      .sel        (sel),
      .led        (led),
      .slice_idx  (slice_idx),
      .has_data   (has_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle; track the dimming phase used at that edge.
   task automatic tick();
      logic r;
      r = rst_n;
      @(posedge clk);
      #1;
      if (r) begin
         pwm_used = pwm_now;
         pwm_now  = (pwm_now + 1) % 8;
      end else begin
         pwm_used = 0;
         pwm_now  = 0;
      end
   endtask

   function automatic logic [3:0] slice_of(input logic [DW-1:0] d, input int k);
      logic [31:0] w;
      w = 32'(d) >> (LW * k);
      return w[3:0];
   endfunction

   function automatic logic [3:0] gate(input logic [3:0] v);
`ifdef LED_PWM_EN
      return (pwm_used < DUTY) ? v : 4'h0;
`else
      return v;
`endif
   endfunction

   // t = edges since the capture/restart edge (t >= 1).
   function automatic logic [3:0] scan_led(input logic [DW-1:0] d, input int t);
      int u;
      u = t - 1;
      if ((u % PER) < DWELL) return slice_of(d, (u / PER) % NS);
      return 4'h0;
   endfunction

   function automatic logic [1:0] scan_idx(input int t);
      return 2'((t / PER) % NS);
   endfunction

   task automatic capture(input logic [DW-1:0] d);
      data_in    = d;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      data_valid = 1'b0;
      repeat (3) tick();
      tests_run++;
      if (led !== 4'h0 || has_data !== 1'b0 || slice_idx !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_state: led=%h has_data=%b idx=%0d, want 0/0/0", led, has_data, slice_idx);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         tests_run++;
         if (led !== 4'h0 || has_data !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_dark: cycle %0d led=%h has_data=%b, want 0/0", i, led, has_data);
         end
      end
   endtask

   task automatic run_scan(input logic [DW-1:0] d, input int n, input string name);
      for (int t = 1; t <= n; t++) begin
         tick();
         tests_run++;
         if (led !== gate(scan_led(d, t)) || slice_idx !== scan_idx(t)) begin
            tests_failed++;
            $display("FAIL %s: t=%0d led=%h idx=%0d, want led=%h idx=%0d",
                     name, t, led, slice_idx, gate(scan_led(d, t)), scan_idx(t));
         end
      end
   endtask

   task automatic test_scan();
      logic [DW-1:0] d;
      scan_en = 1'b1;
      for (int n = 0; n < 4; n++) begin
         d = (n == 0) ? 10'h2A5 : DW'($urandom);
         capture(d);
         tests_run++;
         if (slice_idx !== 2'd0 || has_data !== 1'b1) begin
            tests_failed++;
            $display("FAIL scan_capture: idx=%0d has_data=%b, want 0/1", slice_idx, has_data);
         end
         run_scan(d, 3 * NS * PER + 3, "scan");
      end
   endtask

   task automatic test_recapture();
      logic [DW-1:0] d;
      scan_en = 1'b1;
      capture(10'h2A5);
      run_scan(10'h2A5, 8, "pre_recapture");
      for (int n = 0; n < 3; n++) begin
         d = (n == 0) ? 10'h155 : DW'($urandom);
         capture(d);
         run_scan(d, PER + 2 + n * 3, "recapture");
      end
   endtask

   task automatic test_level_valid();
      logic [DW-1:0] prev;
      scan_en = 1'b1;
      prev = DW'($urandom);
      capture(prev);
      data_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data_in = DW'($urandom);
         tick();
         tests_run++;
         if (led !== gate(slice_of(prev, 0)) || slice_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL level_valid: led=%h idx=%0d, want %h/0", led, slice_idx, gate(slice_of(prev, 0)));
         end
         prev = data_in;
      end
      data_valid = 1'b0;
   endtask

   task automatic test_static();
      logic [DW-1:0] d;
      scan_en = 1'b0;
      for (int n = 0; n < 3; n++) begin
         d = (n == 0) ? 10'h3FF : DW'($urandom);
         capture(d);
         for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            tick();
            for (int i = 0; i < PER + 2; i++) begin
               tests_run++;
               if (led !== gate(slice_of(d, s)) || slice_idx !== 2'(s)) begin
                  tests_failed++;
                  $display("FAIL static: data=%h sel=%0d led=%h idx=%0d, want %h/%0d",
                           d, s, led, slice_idx, gate(slice_of(d, s)), s);
               end
               tick();
            end
         end
      end
   endtask

   task automatic test_mode_change();
      logic [DW-1:0] d;
      d = DW'($urandom);
      scan_en = 1'b1;
      capture(d);
      run_scan(d, 5, "scan_to_gap");
      scan_en = 1'b0;
      sel = 2'd1;
      tick();
      tick();
      tests_run++;
      if (led !== gate(slice_of(d, 1)) || slice_idx !== 2'd1) begin
         tests_failed++;
         $display("FAIL gap_to_static: led=%h idx=%0d, want %h/1", led, slice_idx, gate(slice_of(d, 1)));
      end
      sel = 2'd2;
      repeat (3) tick();
      scan_en = 1'b1;
      tick();
      run_scan(d, 2 * PER + 3, "static_to_scan");
   endtask

   task automatic test_reset_in_gap();
      scan_en = 1'b1;
      capture(DW'($urandom));
      repeat (4) tick();
      rst_n = 1'b0;
      data_valid = 1'b1;
      data_in = DW'($urandom);
      tick();
      tests_run++;
      if (led !== 4'h0 || has_data !== 1'b0 || slice_idx !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_gap: led=%h has_data=%b idx=%0d, want 0/0/0", led, has_data, slice_idx);
      end
      rst_n = 1'b1;
      data_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests_run++;
         if (led !== 4'h0 || has_data !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_gap_idle: led=%h has_data=%b, want 0/0", led, has_data);
         end
      end
   endtask

   task automatic test_pwm();
      int on_cnt;
      int want_on;
      on_cnt = 0;
`ifdef LED_PWM_EN
      want_on = 16 * DUTY / 8;
`else
      want_on = 16;
`endif
      scan_en = 1'b0;
      sel = 2'd0;
      capture(10'h3FF);
      repeat (3) tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         tests_run++;
         if (led !== gate(4'hF)) begin
            tests_failed++;
            $display("FAIL pwm_cycle: led=%h, want %h", led, gate(4'hF));
         end
         if (led == 4'hF) on_cnt++;
      end
      tests_run++;
      if (on_cnt != want_on) begin
         tests_failed++;
         $display("FAIL pwm_duty: lit cycles=%0d, want %0d", on_cnt, want_on);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      data_in    = '0;
      data_valid = 1'b0;
      scan_en    = 1'b1;
      sel        = 2'd0;
      test_reset();
      test_scan();
      test_recapture();
      test_level_valid();
      test_static();
      test_mode_change();
      test_reset_in_gap();
      test_pwm();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
